// File: rtl/dp_sequencer_pkg.sv
// Shared types for the datapath sequencer: ALU/instruction opcodes, FSM states,
// the bundled datapath control word and a few constants.
package dp_sequencer_pkg;

  localparam int IW = 16;
  localparam logic [IW-1:0] IR_RESET = 16'hE000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  // Opcodes 0-7 are register-register ALU ops; op[2:0] is the ALU opcode.
  typedef enum logic [3:0] {
    OP_ADDI = 4'h8,
    OP_LDI  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_BEQZ = 4'hC,
    OP_JMP  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // What the sequencer does with pc/state once EXEC completes.
  typedef enum logic [2:0] {
    FLOW_NEXT   = 3'd0,
    FLOW_BRANCH = 3'd1,
    FLOW_JUMP   = 3'd2,
    FLOW_MEM    = 3'd3,
    FLOW_HALT   = 3'd4
  } flow_e;

  typedef struct packed {
    logic       write_en;
    logic       write_alu;
    logic       is_load;
    logic       alu_imm;
    logic [2:0] alu_op;
    logic [3:0] write_addr;
    logic [3:0] ra_addr;
    logic [3:0] rb_addr;
    logic [7:0] imm;
  } dp_ctrl_t;

  localparam dp_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/dp_sequencer_if.sv
// Bus bundle between the sequencer and its environment: instruction ROM,
// register-file/ALU datapath and the req/ready data RAM.
interface dp_sequencer_if #(
  parameter int PC_W = 8
);

  logic [PC_W-1:0]                 imem_addr;
  logic [dp_sequencer_pkg::IW-1:0] imem_data;

  logic       dp_write_en;
  logic       dp_write_alu;
  logic       dp_is_load;
  logic       dp_alu_imm;
  logic [2:0] dp_alu_op;
  logic [3:0] dp_write_addr;
  logic [3:0] dp_ra_addr;
  logic [3:0] dp_rb_addr;
  logic [7:0] dp_imm;
  logic       dp_alu_zero;
  logic [7:0] dp_read_a;
  logic [7:0] dp_read_b;

  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ready;

  modport master (
    output imem_addr,
    input  imem_data,
    output dp_write_en, dp_write_alu, dp_is_load, dp_alu_imm, dp_alu_op,
    output dp_write_addr, dp_ra_addr, dp_rb_addr, dp_imm,
    input  dp_alu_zero, dp_read_a, dp_read_b,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  dp_write_en, dp_write_alu, dp_is_load, dp_alu_imm, dp_alu_op,
    input  dp_write_addr, dp_ra_addr, dp_rb_addr, dp_imm,
    output dp_alu_zero, dp_read_a, dp_read_b,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready
  );

endinterface

// File: rtl/dp_sequencer_decode.sv
// Pure combinational instruction decode: IR -> datapath control words for the
// EXEC and MEM phases plus the control-flow class of the instruction.
module dp_sequencer_decode
  import dp_sequencer_pkg::*;
(
  input  logic [IW-1:0] ir,
  output dp_ctrl_t      exec_ctrl,
  output dp_ctrl_t      mem_ctrl,
  output dp_ctrl_t      load_ctrl,
  output flow_e         flow,
  output logic          is_store,
  output logic [7:0]    target
);

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] ra;
  logic [3:0] rb;

  assign op       = ir[15:12];
  assign rd       = ir[11:8];
  assign ra       = ir[7:4];
  assign rb       = ir[3:0];
  assign target   = ir[7:0];
  assign is_store = (op == OP_ST);

  always_comb begin
    exec_ctrl = CTRL_NONE;
    flow      = FLOW_NEXT;
    if (!op[3]) begin
      exec_ctrl.write_en   = 1'b1;
      exec_ctrl.write_alu  = 1'b1;
      exec_ctrl.alu_op     = op[2:0];
      exec_ctrl.write_addr = rd;
      exec_ctrl.ra_addr    = ra;
      exec_ctrl.rb_addr    = rb;
    end else begin
      case (op)
        OP_ADDI: begin
          exec_ctrl.write_en   = 1'b1;
          exec_ctrl.write_alu  = 1'b1;
          exec_ctrl.alu_imm    = 1'b1;
          exec_ctrl.alu_op     = ALU_ADD;
          exec_ctrl.write_addr = rd;
          exec_ctrl.ra_addr    = rd;
          exec_ctrl.imm        = ir[7:0];
        end
        OP_LDI: begin
          exec_ctrl.write_en   = 1'b1;
          exec_ctrl.write_addr = rd;
          exec_ctrl.imm        = ir[7:0];
        end
        OP_LD, OP_ST: begin
          exec_ctrl.ra_addr = ra;
          exec_ctrl.rb_addr = rb;
          flow              = FLOW_MEM;
        end
        OP_BEQZ: begin
          // rd OR rd reproduces rd, so the ALU zero flag tests the register.
          exec_ctrl.alu_op  = ALU_OR;
          exec_ctrl.ra_addr = rd;
          exec_ctrl.rb_addr = rd;
          flow              = FLOW_BRANCH;
        end
        OP_JMP:  flow = FLOW_JUMP;
        OP_HALT: flow = FLOW_HALT;
        default: flow = FLOW_NEXT;
      endcase
    end
  end

  always_comb begin
    mem_ctrl         = CTRL_NONE;
    mem_ctrl.ra_addr = ra;
    mem_ctrl.rb_addr = rb;

    load_ctrl            = mem_ctrl;
    load_ctrl.write_en   = 1'b1;
    load_ctrl.is_load    = 1'b1;
    load_ctrl.write_addr = rd;
  end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer: fetches from a sync-read ROM, decodes, drives the
// datapath controls and runs the req/ready handshake for loads and stores.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, all outputs quiet
// S_FETCH  | imem_addr = pc presented to the ROM
// S_DECODE | ROM data valid, captured into IR
// S_EXEC   | controls driven from IR, pc/state updated by instruction class
// S_MEM    | mem_req held until mem_ready, load written in the ready cycle
// S_HALT   | halted = 1 until reset
module dp_sequencer
  import dp_sequencer_pkg::*;
#(
  parameter int PC_W = 8
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  dp_sequencer_if.master  bus,
  output logic            halted,
  output logic [PC_W-1:0] pc
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_target;
  logic [IW-1:0]   ir_q, ir_d;

  dp_ctrl_t   exec_ctrl, mem_ctrl, load_ctrl, ctrl;
  flow_e      flow;
  logic       is_store;
  logic [7:0] target;
  logic       mem_req, mem_we;

  dp_sequencer_decode u_decode (
    .ir        (ir_q),
    .exec_ctrl (exec_ctrl),
    .mem_ctrl  (mem_ctrl),
    .load_ctrl (load_ctrl),
    .flow      (flow),
    .is_store  (is_store),
    .target    (target)
  );

  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_target = PC_W'(target);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= IR_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ctrl    = CTRL_NONE;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = bus.imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ctrl    = exec_ctrl;
        state_d = S_FETCH;
        case (flow)
          FLOW_NEXT:   pc_d = pc_inc;
          FLOW_BRANCH: pc_d = bus.dp_alu_zero ? pc_target : pc_inc;
          FLOW_JUMP:   pc_d = pc_target;
          FLOW_MEM:    state_d = S_MEM;
          FLOW_HALT:   state_d = S_HALT;
          default:     pc_d = pc_inc;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        ctrl    = mem_ctrl;
        if (bus.mem_ready) begin
          // Load data is only valid on the datapath in the ready cycle.
          if (!is_store) ctrl = load_ctrl;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign pc            = pc_q;
  assign bus.imem_addr = pc_q;

  assign bus.dp_write_en   = ctrl.write_en;
  assign bus.dp_write_alu  = ctrl.write_alu;
  assign bus.dp_is_load    = ctrl.is_load;
  assign bus.dp_alu_imm    = ctrl.alu_imm;
  assign bus.dp_alu_op     = ctrl.alu_op;
  assign bus.dp_write_addr = ctrl.write_addr;
  assign bus.dp_ra_addr    = ctrl.ra_addr;
  assign bus.dp_rb_addr    = ctrl.rb_addr;
  assign bus.dp_imm        = ctrl.imm;

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_req ? bus.dp_read_a : 8'h00;
  assign bus.mem_wdata = (mem_req && mem_we) ? bus.dp_read_b : 8'h00;

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer with a small datapath, sync ROM and delayed-ready RAM;
// expected register writes and RAM transactions are queued and checked by a monitor.
module tb_dp_sequencer;
  import dp_sequencer_pkg::*;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            halted;
  logic [PC_W-1:0] pc;

  dp_sequencer_if #(.PC_W(PC_W)) bus ();

  dp_sequencer #(.PC_W(PC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .halted (halted),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  logic [15:0] rom  [256];
  logic [7:0]  ram  [256];
  logic [7:0]  regs [16];
  int          ready_delay = 4;
  int          wait_cnt = 0;
  logic [7:0]  alu_b, alu_y, ram_data, wdata;

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  assign bus.dp_read_a = regs[bus.dp_ra_addr];
  assign bus.dp_read_b = regs[bus.dp_rb_addr];

  always_comb begin
    alu_b = bus.dp_alu_imm ? bus.dp_imm : bus.dp_read_b;
    case (bus.dp_alu_op)
      3'd0:    alu_y = bus.dp_read_a + alu_b;
      3'd1:    alu_y = bus.dp_read_a - alu_b;
      3'd2:    alu_y = bus.dp_read_a & alu_b;
      3'd3:    alu_y = bus.dp_read_a | alu_b;
      3'd4:    alu_y = bus.dp_read_a ^ alu_b;
      3'd5:    alu_y = ~bus.dp_read_a;
      3'd6:    alu_y = bus.dp_read_a << 1;
      default: alu_y = bus.dp_read_a >> 1;
    endcase
  end

  assign bus.dp_alu_zero = (alu_y == 8'h00);
  assign ram_data        = ram[bus.mem_addr];
  assign wdata           = bus.dp_write_alu ? alu_y : (bus.dp_is_load ? ram_data : bus.dp_imm);
  assign bus.mem_ready   = bus.mem_req && (wait_cnt == ready_delay - 1);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else if (bus.dp_write_en && bus.dp_write_addr != 4'd0) begin
      regs[bus.dp_write_addr] <= wdata;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (bus.mem_req && bus.mem_ready && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  end

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         cycles;
  } mem_t;

  wr_t  wr_q[$];
  mem_t mem_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_mem(input logic we, input logic [7:0] a, input logic [7:0] d, input int cyc);
    mem_t m;
    m.we     = we;
    m.addr   = a;
    m.wdata  = d;
    m.cycles = cyc;
    mem_q.push_back(m);
  endtask

  initial begin : monitor
    int   req_cycles;
    wr_t  w;
    mem_t m;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_cycles = 0;
      end else begin
        if (bus.mem_req) req_cycles++;
        else req_cycles = 0;
        if (bus.dp_write_en) begin
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected actual=R%0d<=%0h required=no write", bus.dp_write_addr, wdata);
          end else begin
            w = wr_q.pop_front();
            check("wr_addr", 32'(bus.dp_write_addr), 32'(w.addr));
            check("wr_data", 32'(wdata), 32'(w.data));
          end
          if (bus.dp_is_load) check("ld_in_ready_cycle", 32'(bus.mem_ready), 32'd1);
        end
        if (bus.mem_req && bus.mem_ready) begin
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected actual=addr %0h required=no access", bus.mem_addr);
          end else begin
            m = mem_q.pop_front();
            check("mem_we", 32'(bus.mem_we), 32'(m.we));
            check("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
            check("mem_req_cycles", 32'(req_cycles), 32'(m.cycles));
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string name);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      step(1);
      n++;
    end
    check(name, 32'(halted), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || mem_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(wr_q.size() + mem_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    rst   = 1'b1;
    start = 1'b0;
    clear_rom();

    // Reset and IDLE: everything quiet, start not yet given.
    do_reset();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_ctrl", 32'({bus.dp_write_en, bus.dp_write_alu, bus.dp_is_load, bus.dp_alu_imm,
                          bus.dp_alu_op, bus.dp_write_addr, bus.dp_ra_addr, bus.dp_rb_addr}), 32'd0);
    check("rst_mem", 32'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.dp_imm}), 32'd0);
    step(3);
    check("idle_pc", 32'(pc), 32'd0);

    // LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT
    rom[0] = 16'h9105;
    rom[1] = 16'h9203;
    rom[2] = 16'h0312;
    rom[3] = 16'hF000;
    push_wr(4'd1, 8'h05);
    push_wr(4'd2, 8'h03);
    push_wr(4'd3, 8'h08);
    pulse_start();
    step(11);
    check("halt_not_early", 32'(halted), 32'd0);
    step(1);
    check("halt_cycle13", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'd3);
    check("r3_sum", 32'(regs[3]), 32'h08);
    step(2);
    check("halt_sticky", 32'(halted), 32'd1);
    wait_drain(10, "drain_add");

    // LDI R1,0; ADDI R1,1; BEQZ R0,1 -> R1 counts up and wraps FF->00.
    do_reset();
    clear_rom();
    rom[0] = 16'h9100;
    rom[1] = 16'h8101;
    rom[2] = 16'hC001;
    push_wr(4'd1, 8'h00);
    for (int i = 1; i <= 256; i++) push_wr(4'd1, 8'(i));
    pulse_start();
    wait_drain(2000, "drain_addi_loop");

    // ST M[R4]=R5 then LD R6=M[R4], RAM ready after 4 cycles.
    do_reset();
    clear_rom();
    ready_delay = 4;
    rom[0] = 16'h9410;
    rom[1] = 16'h956C;
    rom[2] = 16'hB045;
    rom[3] = 16'hA640;
    rom[4] = 16'hF000;
    push_wr(4'd4, 8'h10);
    push_wr(4'd5, 8'h6C);
    push_mem(1'b1, 8'h10, 8'h6C, 4);
    push_mem(1'b0, 8'h10, 8'h00, 4);
    push_wr(4'd6, 8'h6C);
    pulse_start();
    wait_halt(200, "mem_halt");
    check("mem_pc", 32'(pc), 32'd4);
    check("ram_10", 32'(ram[8'h10]), 32'h6C);
    check("r6_loaded", 32'(regs[6]), 32'h6C);
    wait_drain(10, "drain_mem");

    // BEQZ taken/not taken, JMP FF, NOP wraps pc to 00.
    do_reset();
    clear_rom();
    rom[8'h00] = 16'h9700;
    rom[8'h01] = 16'hC720;
    rom[8'h20] = 16'h9701;
    rom[8'h21] = 16'hC740;
    rom[8'h22] = 16'hD0FF;
    rom[8'hFF] = 16'hE000;
    push_wr(4'd7, 8'h00);
    push_wr(4'd7, 8'h01);
    pulse_start();
    step(6);
    check("beqz_taken_pc", 32'(pc), 32'h20);
    step(6);
    check("beqz_not_taken_pc", 32'(pc), 32'h22);
    step(3);
    check("jmp_pc", 32'(pc), 32'hFF);
    step(3);
    check("pc_wrap", 32'(pc), 32'h00);
    do_reset();
    wait_drain(10, "drain_branch");

    // Reset during a long RAM wait abandons the store; start restarts at 0.
    clear_rom();
    ready_delay = 20;
    rom[0] = 16'h9430;
    rom[1] = 16'hB044;
    rom[2] = 16'hF000;
    push_wr(4'd4, 8'h30);
    pulse_start();
    n = 0;
    while (!bus.mem_req && n < 50) begin
      step(1);
      n++;
    end
    check("mem_req_seen", 32'(bus.mem_req), 32'd1);
    step(2);
    rst = 1'b1;
    step(1);
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_mem_pc", 32'(pc), 32'd0);
    rst = 1'b0;
    step(2);
    check("rst_mid_mem_idle", 32'({bus.mem_req, pc, halted}), 32'd0);
    ready_delay = 3;
    push_wr(4'd4, 8'h30);
    push_mem(1'b1, 8'h30, 8'h30, 3);
    pulse_start();
    wait_halt(200, "restart_halt");
    check("restart_pc", 32'(pc), 32'd2);
    check("ram_30", 32'(ram[8'h30]), 32'h30);
    wait_drain(10, "drain_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
